// File: rtl/elevator_call_panel_if.sv
// Call-panel bus: raw buttons and current floor in, call pulse, floor value and lamps out.
// The panel takes the master side; the controller or bench takes the slave side.
interface elevator_call_panel_if #(
  parameter int N_FLOORS = 8,
  parameter int FLOOR_W  = 3
);
  logic [N_FLOORS-1:0] i_buttons;
  logic [FLOOR_W-1:0]  i_current_floor;
  logic                o_button_pressed;
  logic [FLOOR_W-1:0]  o_button_value;
  logic [N_FLOORS-1:0] o_pending;

  modport master (
    input  i_buttons,
    input  i_current_floor,
    output o_button_pressed,
    output o_button_value,
    output o_pending
  );

  modport slave (
    output i_buttons,
    output i_current_floor,
    input  o_button_pressed,
    input  o_button_value,
    input  o_pending
  );
endinterface

// File: rtl/elevator_call_panel.sv
// Floor-button front end: synchronise, debounce and edge-detect the presses, keep the
// lamp bits, and issue each new call once as a spaced single-cycle pulse.
//
// state   | meaning
// S_IDLE  | look for a pending, un-issued floor other than the current one
// S_ISSUE | drive the one-cycle call pulse for the selected floor
// S_GAP   | forced idle cycles after a pulse
module elevator_call_panel #(
  parameter int N_FLOORS        = 8,
  parameter int FLOOR_W         = 3,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int GAP_CYCLES      = 2
) (
  input logic                   i_clk,
  input logic                   i_rst,
  elevator_call_panel_if.master bus
);
  localparam int DCNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int GCNT_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [DCNT_W-1:0] DCNT_LAST = DCNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [GCNT_W-1:0] GAP_LAST  = GCNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_GAP   = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [N_FLOORS-1:0] sync_1, sync_2;
  logic [N_FLOORS-1:0] deb, deb_d;
  logic [DCNT_W-1:0]   dcnt [N_FLOORS];
  logic [N_FLOORS-1:0] press;

  logic [N_FLOORS-1:0] pending, issued;
  logic [N_FLOORS-1:0] visit;
  logic [N_FLOORS-1:0] issue_set;
  logic [N_FLOORS-1:0] cand;
  logic                cand_any;
  logic [FLOOR_W-1:0]  cand_sel;
  logic [FLOOR_W-1:0]  idx;
  logic                found;

  logic [FLOOR_W-1:0]  rr_ptr;
  logic [FLOOR_W-1:0]  sel_q;
  logic [GCNT_W-1:0]   gap_cnt;

  // Two-flop synchroniser feeding a per-button consecutive-mismatch counter.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sync_1 <= '0;
      sync_2 <= '0;
      deb    <= '0;
      deb_d  <= '0;
      for (int k = 0; k < N_FLOORS; k++) dcnt[k] <= '0;
    end else begin
      sync_1 <= bus.i_buttons;
      sync_2 <= sync_1;
      deb_d  <= deb;
      for (int k = 0; k < N_FLOORS; k++) begin
        if (sync_2[k] == deb[k]) begin
          dcnt[k] <= '0;
        end else if (dcnt[k] == DCNT_LAST) begin
          deb[k]  <= sync_2[k];
          dcnt[k] <= '0;
        end else begin
          dcnt[k] <= dcnt[k] + 1'b1;
        end
      end
    end
  end

  assign press = deb & ~deb_d;

  always_comb begin
    visit = '0;
    visit[bus.i_current_floor] = 1'b1;
    issue_set = '0;
    if (state == S_ISSUE) issue_set[sel_q] = 1'b1;
  end

  // A visit beats both a same-cycle press and the issue marking.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      pending <= '0;
      issued  <= '0;
    end else begin
      pending <= (pending | press) & ~visit;
      issued  <= ((issued | issue_set) & ~(press & ~pending)) & ~visit;
    end
  end

  // Round-robin search upward from rr_ptr, wrapping at N_FLOORS.
  always_comb begin
    cand     = pending & ~issued & ~visit;
    cand_any = |cand;
    cand_sel = '0;
    found    = 1'b0;
    idx      = '0;
    for (int i = 0; i < N_FLOORS; i++) begin
      idx = rr_ptr + FLOOR_W'(i);
      if (!found && cand[idx]) begin
        cand_sel = idx;
        found    = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rr_ptr  <= '0;
      sel_q   <= '0;
      gap_cnt <= '0;
    end else begin
      if (state == S_IDLE && cand_any) sel_q <= cand_sel;
      if (state == S_ISSUE) begin
        rr_ptr  <= sel_q + 1'b1;
        gap_cnt <= '0;
      end else if (state == S_GAP) begin
        gap_cnt <= gap_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (cand_any) state_nxt = S_ISSUE;
      S_ISSUE: state_nxt = (GAP_CYCLES > 0) ? S_GAP : S_IDLE;
      S_GAP:   if (gap_cnt == GAP_LAST) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    bus.o_button_pressed = 1'b0;
    bus.o_button_value   = sel_q;
    if (state == S_ISSUE) bus.o_button_pressed = 1'b1;
  end

  assign bus.o_pending = pending;

endmodule

// File: tb/tb_elevator_call_panel.sv
// Bench for elevator_call_panel: directed scenarios plus random buttons and floor moves,
// checked against a sample-history reference model through a pulse scoreboard.
module tb_elevator_call_panel;
  localparam int N  = 8;
  localparam int FW = 3;
  localparam int D  = 4;
  localparam int G  = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  elevator_call_panel_if #(.N_FLOORS(N), .FLOOR_W(FW)) bus_if ();

  elevator_call_panel #(
    .N_FLOORS(N), .FLOOR_W(FW), .DEBOUNCE_CYCLES(D), .GAP_CYCLES(G)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .bus  (bus_if)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int cyc = 0;
  int pulse_count = 0;
  int last_value  = -1;
  int last_pulse_cyc = -1000;
  bit mon_en = 1'b0;
  int seen_q[$];

  // Reference model: debounced level flips once the last D synchronised samples all
  // disagree with it; issuer is ready again G+2 edges after each pulse decision.
  bit [N-1:0] m_pend, m_iss, m_deb, m_rose;
  bit [N-1:0] m_hist [0:D];
  int m_rr, m_busy, m_issue_floor;
  bit exp_now;
  int exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else n_pass++;
  endtask

  task automatic model_edge(input logic [N-1:0] b, input logic [FW-1:0] cf, input logic r);
    bit pulse;
    int sel;
    int f;
    bit [N-1:0] rose;
    bit v;
    bit same;
    if (r) begin
      m_pend = '0; m_iss = '0; m_deb = '0; m_rose = '0;
      for (int i = 0; i <= D; i++) m_hist[i] = '0;
      m_rr = 0; m_busy = 0; m_issue_floor = -1;
      exp_now = 1'b0;
      exp_q.delete();
      last_pulse_cyc = -1000;
      return;
    end
    pulse = 1'b0;
    sel = 0;
    if (m_busy > 0) begin
      m_busy--;
    end else begin
      for (int i = 0; i < N; i++) begin
        f = (m_rr + i) % N;
        if (!pulse && m_pend[f] && !m_iss[f] && f != int'(cf)) begin
          pulse = 1'b1;
          sel = f;
        end
      end
    end
    if (m_issue_floor >= 0) begin
      m_iss[m_issue_floor] = 1'b1;
      m_issue_floor = -1;
    end
    for (int k = 0; k < N; k++) begin
      if (int'(cf) == k) begin
        m_pend[k] = 1'b0;
        m_iss[k]  = 1'b0;
      end else if (m_rose[k] && !m_pend[k]) begin
        m_pend[k] = 1'b1;
        m_iss[k]  = 1'b0;
      end
    end
    exp_now = pulse;
    if (pulse) begin
      m_issue_floor = sel;
      m_rr = (sel + 1) % N;
      m_busy = G + 1;
      exp_q.push_back(sel);
    end
    for (int k = 0; k < N; k++) begin
      v = m_hist[1][k];
      same = 1'b1;
      for (int i = 2; i <= D; i++) if (m_hist[i][k] != v) same = 1'b0;
      rose[k] = 1'b0;
      if (same && v != m_deb[k]) begin
        m_deb[k] = v;
        rose[k]  = v;
      end
    end
    m_rose = rose;
    for (int i = D; i > 0; i--) m_hist[i] = m_hist[i-1];
    m_hist[0] = b;
  endtask

  task automatic step(input logic [N-1:0] b, input logic [FW-1:0] cf, input logic r);
    bus_if.i_buttons = b;
    bus_if.i_current_floor = cf;
    rst = r;
    @(posedge clk);
    model_edge(b, cf, r);
    #1;
  endtask

  task automatic steps(input int n, input logic [N-1:0] b, input logic [FW-1:0] cf);
    for (int i = 0; i < n; i++) step(b, cf, 1'b0);
  endtask

  // Monitor: pops the scoreboard on each DUT pulse, independent of stimulus.
  always @(negedge clk) begin
    cyc++;
    if (mon_en) begin
      check("pulse", bus_if.o_button_pressed, exp_now);
      check("pending", bus_if.o_pending, m_pend);
      if (bus_if.o_button_pressed) begin
        pulse_count++;
        last_value = int'(bus_if.o_button_value);
        seen_q.push_back(last_value);
        check("spacing_ok", (cyc - last_pulse_cyc) >= (G + 2), 1'b1);
        last_pulse_cyc = cyc;
        if (exp_q.size() > 0) begin
          check("value", bus_if.o_button_value, exp_q.pop_front());
        end else begin
          n_checks++;
          $display("FAIL unexpected_pulse: got value %0d expected no pulse", bus_if.o_button_value);
        end
      end else if (exp_now && exp_q.size() > 0) begin
        void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    int pc;
    bit found;
    logic [N-1:0] raw;
    logic [FW-1:0] cur;
    int hold;

    bus_if.i_buttons = '0;
    bus_if.i_current_floor = '0;
    step('0, '0, 1'b1);
    mon_en = 1'b1;
    step('0, '0, 1'b1);
    check("rst_pressed", bus_if.o_button_pressed, 1'b0);
    check("rst_value", bus_if.o_button_value, 3'd0);
    check("rst_pending", bus_if.o_pending, 8'h00);

    // clean press of floor 5
    pc = pulse_count;
    steps(7, 8'h20, 3'd0);
    check("s1_pending_edge6", bus_if.o_pending, 8'h20);
    check("s1_no_pulse_yet", bus_if.o_button_pressed, 1'b0);
    step(8'h20, 3'd0, 1'b0);
    check("s1_pulse_edge7", bus_if.o_button_pressed, 1'b1);
    check("s1_value_edge7", bus_if.o_button_value, 3'd5);
    steps(2, 8'h20, 3'd0);
    steps(10, 8'h00, 3'd0);
    check("s1_pulse_count", pulse_count - pc, 1);
    check("s1_pending_held", bus_if.o_pending, 8'h20);
    step(8'h00, 3'd5, 1'b0);
    check("s1_cleared", bus_if.o_pending, 8'h00);

    // bouncing floor 3
    pc = pulse_count;
    for (int i = 0; i < 20; i++) step((i % 2) ? 8'h08 : 8'h00, 3'd0, 1'b0);
    check("s2_no_pending_bounce", bus_if.o_pending, 8'h00);
    steps(12, 8'h08, 3'd0);
    steps(6, 8'h00, 3'd0);
    check("s2_pulse_count", pulse_count - pc, 1);
    check("s2_value", last_value, 3);
    step(8'h00, 3'd3, 1'b0);

    // simultaneous 2, 6, 1 from rr_ptr=0
    step('0, '0, 1'b1);
    seen_q.delete();
    steps(8, 8'h46, 3'd0);
    steps(12, 8'h00, 3'd0);
    check("s3_pending", bus_if.o_pending, 8'h46);
    check("s3_count", seen_q.size(), 3);
    if (seen_q.size() == 3) begin
      check("s3_first", seen_q[0], 1);
      check("s3_second", seen_q[1], 2);
      check("s3_third", seen_q[2], 6);
    end
    step(8'h00, 3'd1, 1'b0);
    step(8'h00, 3'd2, 1'b0);
    step(8'h00, 3'd6, 1'b0);
    step(8'h00, 3'd0, 1'b0);
    check("s3_cleared", bus_if.o_pending, 8'h00);

    // duplicate press of floor 4, visit, re-press
    pc = pulse_count;
    steps(8, 8'h10, 3'd0);
    steps(6, 8'h00, 3'd0);
    steps(8, 8'h10, 3'd0);
    steps(8, 8'h00, 3'd0);
    check("s4_dup_ignored", pulse_count - pc, 1);
    step(8'h00, 3'd4, 1'b0);
    check("s4_cleared", bus_if.o_pending, 8'h00);
    steps(8, 8'h10, 3'd0);
    steps(6, 8'h00, 3'd0);
    check("s4_reissue_count", pulse_count - pc, 2);
    check("s4_reissue_value", last_value, 4);
    step(8'h00, 3'd4, 1'b0);

    // press on the current floor is dropped
    pc = pulse_count;
    steps(8, 8'h01, 3'd0);
    steps(6, 8'h00, 3'd0);
    check("s5_pending", bus_if.o_pending, 8'h00);
    check("s5_no_pulse", pulse_count - pc, 0);

    // reset while in the gap, floor 7 held through it
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      step(8'h84, 3'd0, 1'b0);
      if (bus_if.o_button_pressed) found = 1'b1;
    end
    check("s6_pulse_seen", found, 1'b1);
    step(8'h84, 3'd0, 1'b0);
    step(8'h80, 3'd0, 1'b1);
    check("s6_rst_pressed", bus_if.o_button_pressed, 1'b0);
    check("s6_rst_value", bus_if.o_button_value, 3'd0);
    check("s6_rst_pending", bus_if.o_pending, 8'h00);
    pc = pulse_count;
    steps(7, 8'h80, 3'd0);
    check("s6_no_early_pulse", pulse_count - pc, 0);
    step(8'h80, 3'd0, 1'b0);
    check("s6_reissue_pulse", bus_if.o_button_pressed, 1'b1);
    check("s6_reissue_value", bus_if.o_button_value, 3'd7);
    steps(4, 8'h00, 3'd0);
    step(8'h00, 3'd7, 1'b0);

    // random phase
    step('0, '0, 1'b1);
    raw = '0;
    cur = '0;
    hold = 5;
    for (int c = 0; c < 4000; c++) begin
      for (int k = 0; k < N; k++) if ($urandom_range(0, 59) == 0) raw[k] = ~raw[k];
      if (hold == 0) begin
        cur = FW'($urandom_range(0, N - 1));
        hold = $urandom_range(2, 30);
      end else begin
        hold--;
      end
      step(raw, cur, ($urandom_range(0, 1999) == 0));
    end
    steps(20, 8'h00, 3'd0);
    check("queue_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
